// File: rtl/text_console_writer.sv
// Character-stream writer for the 80x30 text framebuffer: places characters at a
// hardware cursor, handles LF/CR/BS/FF and wrap, and clears rows as they are entered.
module text_console_writer #(
    parameter int          COLS     = 80,
    parameter int          ROWS     = 30,
    parameter logic [31:0] BASE_ADR = 32'd160
) (
    input  logic        dclk,
    input  logic        clr,
    input  logic        in_valid,
    input  logic [7:0]  in_char,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_adr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic [6:0]  cursor_col,
    output logic [4:0]  cursor_row,
    output logic        busy
);

    localparam int WORDS_ROW = COLS / 4;
    localparam int WORDS_ALL = ROWS * WORDS_ROW;
    localparam int IDX_W     = $clog2(WORDS_ALL);

    localparam logic [31:0]      WROW32       = 32'(WORDS_ROW);
    localparam logic [IDX_W-1:0] LAST_ROW_IDX = IDX_W'(WORDS_ROW - 1);
    localparam logic [IDX_W-1:0] LAST_ALL_IDX = IDX_W'(WORDS_ALL - 1);
    localparam logic [6:0]       LAST_COL     = 7'(COLS - 1);
    localparam logic [4:0]       LAST_ROW     = 5'(ROWS - 1);
    localparam logic [31:0]      BLANKS       = 32'h2020_2020;

    typedef enum logic [1:0] {IDLE, WRITE, CLR_ROW, CLR_ALL} state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             row_pend;
    logic [6:0]       col_dec;
    logic [4:0]       row_next;

    assign in_ready = (state == IDLE);
    assign busy     = (state == CLR_ROW) || (state == CLR_ALL);
    assign col_dec  = cursor_col - 7'd1;
    assign row_next = (cursor_row == LAST_ROW) ? 5'd0 : cursor_row + 5'd1;

    function automatic logic [31:0] word_adr(input logic [31:0] word);
        return BASE_ADR + (word << 2);
    endfunction

    function automatic logic [31:0] row_word(input logic [4:0] r);
        return 32'(r) * WROW32;
    endfunction

    // row_pend remembers that a wrapping character still owes a row clear after its gap cycle
    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            state      <= CLR_ALL;
            idx        <= '0;
            row_pend   <= 1'b0;
            cursor_col <= 7'd0;
            cursor_row <= 5'd0;
            mem_we     <= 1'b0;
            mem_adr    <= 32'd0;
            mem_wdata  <= 32'd0;
            mem_be     <= 4'd0;
        end else begin
            mem_we <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (in_char >= 8'h20 && in_char <= 8'h7E) begin
                            mem_we    <= 1'b1;
                            mem_adr   <= word_adr(row_word(cursor_row) + 32'(cursor_col[6:2]));
                            mem_wdata <= {4{in_char}};
                            mem_be    <= 4'b0001 << cursor_col[1:0];
                            state     <= WRITE;
                            if (cursor_col == LAST_COL) begin
                                cursor_col <= 7'd0;
                                cursor_row <= row_next;
                                row_pend   <= 1'b1;
                            end else begin
                                cursor_col <= cursor_col + 7'd1;
                                row_pend   <= 1'b0;
                            end
                        end else if (in_char == 8'h0A) begin
                            cursor_col <= 7'd0;
                            cursor_row <= row_next;
                            idx        <= '0;
                            state      <= CLR_ROW;
                        end else if (in_char == 8'h0D) begin
                            cursor_col <= 7'd0;
                        end else if (in_char == 8'h08) begin
                            if (cursor_col != 7'd0) begin
                                cursor_col <= col_dec;
                                mem_we     <= 1'b1;
                                mem_adr    <= word_adr(row_word(cursor_row) + 32'(col_dec[6:2]));
                                mem_wdata  <= BLANKS;
                                mem_be     <= 4'b0001 << col_dec[1:0];
                                row_pend   <= 1'b0;
                                state      <= WRITE;
                            end
                        end else if (in_char == 8'h0C) begin
                            cursor_col <= 7'd0;
                            cursor_row <= 5'd0;
                            idx        <= '0;
                            state      <= CLR_ALL;
                        end
                    end
                end
                WRITE: begin
                    idx      <= '0;
                    row_pend <= 1'b0;
                    state    <= row_pend ? CLR_ROW : IDLE;
                end
                CLR_ROW: begin
                    mem_we    <= 1'b1;
                    mem_adr   <= word_adr(row_word(cursor_row) + 32'(idx));
                    mem_wdata <= BLANKS;
                    mem_be    <= 4'hF;
                    if (idx == LAST_ROW_IDX) state <= IDLE;
                    else                     idx   <= idx + 1'b1;
                end
                CLR_ALL: begin
                    mem_we    <= 1'b1;
                    mem_adr   <= word_adr(32'(idx));
                    mem_wdata <= BLANKS;
                    mem_be    <= 4'hF;
                    if (idx == LAST_ALL_IDX) state <= IDLE;
                    else                     idx   <= idx + 1'b1;
                end
                default: state <= CLR_ALL;
            endcase
        end
    end

endmodule

// File: tb/tb_text_console_writer.sv
// Directed self-checking bench for text_console_writer: records every memory write
// and compares against hand-computed addresses, data, lanes and cursor positions.
module tb_text_console_writer;

    logic        dclk = 1'b0;
    logic        clr = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_char = 8'h00;
    logic        in_ready, mem_we, busy;
    logic [31:0] mem_adr, mem_wdata;
    logic [3:0]  mem_be;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] wd;
        logic [3:0]  be;
    } wr_t;
    wr_t wq[$];

    text_console_writer dut (
        .dclk(dclk), .clr(clr), .in_valid(in_valid), .in_char(in_char),
        .in_ready(in_ready), .mem_we(mem_we), .mem_adr(mem_adr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .cursor_col(cursor_col),
        .cursor_row(cursor_row), .busy(busy)
    );

    always #5 dclk = ~dclk;

    always @(negedge dclk) begin
        if (mem_we === 1'b1) wq.push_back('{adr: mem_adr, wd: mem_wdata, be: mem_be});
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] c);
        int n = 0;
        in_valid = 1'b1;
        in_char  = c;
        while (!in_ready && n < 2000) begin
            @(posedge dclk); #1;
            n++;
        end
        if (!in_ready) checkOutput("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge dclk); #1;
        in_valid = 1'b0;
    endtask

    task automatic sendN(input int n, input logic [7:0] c);
        for (int i = 0; i < n; i++) applyStimulus(c);
    endtask

    task automatic waitReady(input string tag, input int budget);
        int n = 0;
        while (!in_ready && n < budget) begin
            @(posedge dclk); #1;
            n++;
        end
        checkOutput(tag, 32'(in_ready), 32'd1);
        @(posedge dclk); #1;
    endtask

    task automatic checkClearAll(input string tag);
        int bad = 0;
        checkOutput({tag, "_count"}, 32'(wq.size()), 32'd600);
        for (int i = 0; i < wq.size(); i++) begin
            if (wq[i].adr !== 32'd160 + 32'(i) * 4 || wq[i].wd !== 32'h20202020 || wq[i].be !== 4'hF)
                bad++;
        end
        checkOutput({tag, "_bad_writes"}, 32'(bad), 32'd0);
        checkOutput({tag, "_col"}, 32'(cursor_col), 32'd0);
        checkOutput({tag, "_row"}, 32'(cursor_row), 32'd0);
    endtask

    initial begin
        int busy_cnt;
        int qcnt;
        int bad;

        // Reset state and the power-up full clear
        repeat (3) @(posedge dclk);
        #1;
        checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
        checkOutput("rst_mem_adr", mem_adr, 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd1);
        @(negedge dclk);
        clr = 1'b0;
        @(posedge dclk); #1;
        checkOutput("first_clr_we", 32'(mem_we), 32'd1);
        checkOutput("first_clr_adr", mem_adr, 32'd160);
        waitReady("rst_ready", 700);
        checkClearAll("rst_clrall");
        checkOutput("rst_busy_done", 32'(busy), 32'd0);

        // Printable characters
        wq.delete();
        applyStimulus(8'h41);
        checkOutput("A_we", 32'(mem_we), 32'd1);
        checkOutput("A_adr", mem_adr, 32'd160);
        checkOutput("A_wdata", mem_wdata, 32'h41414141);
        checkOutput("A_be", 32'(mem_be), 32'h1);
        checkOutput("A_col", 32'(cursor_col), 32'd1);
        checkOutput("A_ready_low", 32'(in_ready), 32'd0);
        @(posedge dclk); #1;
        checkOutput("A_ready_back", 32'(in_ready), 32'd1);
        checkOutput("A_we_off", 32'(mem_we), 32'd0);
        sendN(4, 8'h42);
        applyStimulus(8'h46);
        checkOutput("col5_adr", mem_adr, 32'd164);
        checkOutput("col5_be", 32'(mem_be), 32'h2);
        checkOutput("col5_wdata", mem_wdata, 32'h46464646);

        // Line feed from (10,3)
        sendN(3, 8'h0A);
        sendN(10, 8'h43);
        checkOutput("pre_lf_col", 32'(cursor_col), 32'd10);
        checkOutput("pre_lf_row", 32'(cursor_row), 32'd3);
        @(posedge dclk); #1;
        wq.delete();
        applyStimulus(8'h0A);
        checkOutput("lf_col", 32'(cursor_col), 32'd0);
        checkOutput("lf_row", 32'(cursor_row), 32'd4);
        busy_cnt = 0;
        for (int n = 0; n < 100 && !in_ready; n++) begin
            if (busy) busy_cnt++;
            @(posedge dclk); #1;
        end
        checkOutput("lf_busy_cycles", 32'(busy_cnt), 32'd20);
        waitReady("lf_ready", 10);
        checkOutput("lf_count", 32'(wq.size()), 32'd20);
        bad = 0;
        for (int i = 0; i < wq.size(); i++)
            if (wq[i].adr !== 32'd480 + 32'(i) * 4 || wq[i].wd !== 32'h20202020 || wq[i].be !== 4'hF) bad++;
        checkOutput("lf_bad_writes", 32'(bad), 32'd0);

        // End-of-line wrap on the last row
        sendN(25, 8'h0A);
        checkOutput("wrap_start_row", 32'(cursor_row), 32'd29);
        sendN(79, 8'h2E);
        @(posedge dclk); #1;
        wq.delete();
        applyStimulus(8'h5A);
        checkOutput("wrap_adr", mem_adr, 32'd2556);
        checkOutput("wrap_be", 32'(mem_be), 32'h8);
        checkOutput("wrap_wdata", mem_wdata, 32'h5A5A5A5A);
        waitReady("wrap_ready", 100);
        checkOutput("wrap_count", 32'(wq.size()), 32'd21);
        if (wq.size() == 21) begin
            checkOutput("wrap_clr_first", wq[1].adr, 32'd160);
            checkOutput("wrap_clr_last", wq[20].adr, 32'd236);
            checkOutput("wrap_clr_be", 32'(wq[20].be), 32'hF);
        end
        checkOutput("wrap_col", 32'(cursor_col), 32'd0);
        checkOutput("wrap_row", 32'(cursor_row), 32'd0);

        // Backspace, carriage return, ignored code
        sendN(2, 8'h0A);
        sendN(5, 8'h61);
        @(posedge dclk); #1;
        applyStimulus(8'h08);
        checkOutput("bs_col", 32'(cursor_col), 32'd4);
        checkOutput("bs_row", 32'(cursor_row), 32'd2);
        checkOutput("bs_we", 32'(mem_we), 32'd1);
        checkOutput("bs_adr", mem_adr, 32'd324);
        checkOutput("bs_wdata", mem_wdata, 32'h20202020);
        checkOutput("bs_be", 32'(mem_be), 32'h1);
        applyStimulus(8'h0D);
        @(posedge dclk); #1;
        wq.delete();
        applyStimulus(8'h08);
        repeat (2) @(posedge dclk);
        #1;
        checkOutput("bs0_writes", 32'(wq.size()), 32'd0);
        checkOutput("bs0_col", 32'(cursor_col), 32'd0);
        sendN(5, 8'h0A);
        sendN(9, 8'h62);
        @(posedge dclk); #1;
        wq.delete();
        applyStimulus(8'h0D);
        checkOutput("cr_ready", 32'(in_ready), 32'd1);
        repeat (2) @(posedge dclk);
        #1;
        checkOutput("cr_writes", 32'(wq.size()), 32'd0);
        checkOutput("cr_col", 32'(cursor_col), 32'd0);
        checkOutput("cr_row", 32'(cursor_row), 32'd7);
        sendN(3, 8'h63);
        @(posedge dclk); #1;
        wq.delete();
        applyStimulus(8'h07);
        checkOutput("bel_ready", 32'(in_ready), 32'd1);
        repeat (2) @(posedge dclk);
        #1;
        checkOutput("bel_writes", 32'(wq.size()), 32'd0);
        checkOutput("bel_col", 32'(cursor_col), 32'd3);
        checkOutput("bel_row", 32'(cursor_row), 32'd7);

        // Form feed
        wq.delete();
        applyStimulus(8'h0C);
        checkOutput("ff_busy", 32'(busy), 32'd1);
        waitReady("ff_ready", 700);
        checkClearAll("ff_clrall");

        // Reset in the middle of a row clear
        applyStimulus(8'h0A);
        repeat (5) @(posedge dclk);
        #2;
        checkOutput("abort_busy_before", 32'(busy), 32'd1);
        clr = 1'b1;
        #1;
        checkOutput("abort_we", 32'(mem_we), 32'd0);
        checkOutput("abort_in_ready", 32'(in_ready), 32'd0);
        @(negedge dclk);
        wq.delete();
        clr = 1'b0;
        waitReady("abort_ready", 700);
        checkClearAll("abort_clrall");

        // Character held while a clear is in progress
        wq.delete();
        applyStimulus(8'h0A);
        applyStimulus(8'h51);
        checkOutput("hold_adr", mem_adr, 32'd240);
        checkOutput("hold_be", 32'(mem_be), 32'h1);
        repeat (3) @(posedge dclk);
        #1;
        qcnt = 0;
        for (int i = 0; i < wq.size(); i++) if (wq[i].wd === 32'h51515151) qcnt++;
        checkOutput("hold_once", 32'(qcnt), 32'd1);
        checkOutput("hold_col", 32'(cursor_col), 32'd1);
        checkOutput("hold_row", 32'(cursor_row), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
